// File: rtl/multi_pixel_buffer.sv
// Per-channel pixel FIFOs merged round-robin into one registered output stream.
// Also counts pops and pulses frame_done on the last pixel of each frame.
module multi_pixel_buffer #(
    parameter int NUM_CH       = 3,
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int AF_MARGIN    = 2,
    parameter int FRAME_PIXELS = 307200,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       we,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       almost_full,
    output logic [NUM_CH-1:0]       ovf,
    input  logic                    re,
    output logic [WIDTH-1:0]        data_out,
    output logic [CW-1:0]           ch_out,
    output logic                    empty,
    output logic                    frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIXELS - 1);

    logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [AW-1:0]    wptr [NUM_CH];
    logic [AW-1:0]    rptr [NUM_CH];
    logic [AW:0]      cnt  [NUM_CH];

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_ch;
    logic [CW-1:0]    last_grant;
    logic [PW-1:0]    pix_cnt;

    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] accept;
    logic [NUM_CH-1:0] take;
    logic [CW-1:0]     grant;
    logic              found;
    logic              load;
    logic              pop;
    int                idx;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]        = (cnt[i] == CNT_FULL);
            almost_full[i] = (cnt[i] >= CNT_AF);
            nonempty[i]    = (cnt[i] != '0);
            accept[i]      = we[i] & ~full[i];
        end
    end

    // First non-empty channel after last_grant, wrapping modulo NUM_CH.
    always_comb begin
        grant = last_grant;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    assign load = (~out_valid | re) & found;
    assign pop  = re & out_valid;

    always_comb begin
        take = '0;
        if (load) take[grant] = 1'b1;
    end

    assign frame_done = pop & (pix_cnt == PIX_LAST);
    assign data_out   = out_data;
    assign ch_out     = out_ch;
    assign empty      = ~out_valid;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) mem[i][wptr[i]] <= data_in[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            ovf        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= CW'(NUM_CH - 1);
            pix_cnt    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept[i]) wptr[i] <= wptr[i] + AW'(1);
                if (take[i])   rptr[i] <= rptr[i] + AW'(1);
                if (we[i] && full[i]) ovf[i] <= 1'b1;
                cnt[i] <= cnt[i] + (AW+1)'(accept[i]) - (AW+1)'(take[i]);
            end
            if (load) begin
                out_valid  <= 1'b1;
                out_data   <= mem[grant][rptr[grant]];
                out_ch     <= grant;
                last_grant <= grant;
            end else begin
                out_valid  <= out_valid & ~re;
            end
            if (pop) pix_cnt <= frame_done ? '0 : pix_cnt + PW'(1);
        end
    end

endmodule

// File: tb/tb_multi_pixel_buffer.sv
// Scoreboard bench for multi_pixel_buffer: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_multi_pixel_buffer;

    localparam int NC  = 3;
    localparam int W   = 8;
    localparam int D   = 4;
    localparam int AFM = 1;
    localparam int FP  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] we;
    logic [NC*W-1:0] data_in;
    logic [NC-1:0] full, almost_full, ovf;
    logic          re;
    logic [W-1:0]  data_out;
    logic [1:0]    ch_out;
    logic          empty, frame_done;

    multi_pixel_buffer #(
        .NUM_CH(NC), .WIDTH(W), .DEPTH(D), .AF_MARGIN(AFM), .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .data_in(data_in),
        .full(full), .almost_full(almost_full), .ovf(ovf),
        .re(re), .data_out(data_out), .ch_out(ch_out),
        .empty(empty), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] d;
    } ent_t;

    int checks = 0;
    int failures = 0;

    logic [7:0] mq [NC][$];
    ent_t       exp_q [$];
    bit         m_valid;
    int         m_last;
    logic [NC-1:0] m_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model of one clock edge using the inputs currently applied.
    task automatic model_step();
        bit   acc [NC];
        bit   any;
        int   c;
        ent_t e;
        if (rst) begin
            for (int i = 0; i < NC; i++) mq[i].delete();
            exp_q.delete();
            m_valid = 0;
            m_last  = NC - 1;
            m_ovf   = '0;
            return;
        end
        any = 0;
        for (int i = 0; i < NC; i++) begin
            acc[i] = we[i] && (mq[i].size() < D);
            if (we[i] && !acc[i]) m_ovf[i] = 1'b1;
            if (mq[i].size() > 0) any = 1;
        end
        if ((!m_valid || re) && any) begin
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (mq[c].size() > 0) break;
            end
            e.ch = 2'(c);
            e.d  = mq[c].pop_front();
            exp_q.push_back(e);
            m_last  = c;
            m_valid = 1;
        end else if (re) begin
            m_valid = 0;
        end
        for (int i = 0; i < NC; i++)
            if (acc[i]) mq[i].push_back(data_in[i*W +: W]);
    endtask

    task automatic check_flags();
        logic [NC-1:0] f, af;
        for (int i = 0; i < NC; i++) begin
            f[i]  = (mq[i].size() == D);
            af[i] = (mq[i].size() >= D - AFM);
        end
        check("full", full, f);
        check("almost_full", almost_full, af);
        check("ovf", ovf, m_ovf);
        check("empty", empty, !m_valid);
    endtask

    task automatic step(input logic r, input logic [NC-1:0] w,
                        input logic [NC*W-1:0] d, input logic rd);
        @(negedge clk);
        check_flags();
        rst = r; we = w; data_in = d; re = rd;
        @(posedge clk);
        model_step();
    endtask

    // Monitor: compares the presented head against the scoreboard and
    // tracks frame position independently of the stimulus.
    initial begin : monitor
        int pix;
        bit fd;
        pix = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pix = 0;
            end else begin
                fd = re && !empty && (pix == FP - 1);
                check("frame_done", frame_done, fd);
                if (!empty) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 1, 0);
                    end else begin
                        check("data_out", data_out, exp_q[0].d);
                        check("ch_out", ch_out, exp_q[0].ch);
                        if (re) void'(exp_q.pop_front());
                    end
                end
                if (re && !empty) pix = (pix + 1) % FP;
            end
        end
    end

    function automatic logic [NC*W-1:0] rnd_data();
        return (NC*W)'({$urandom, $urandom});
    endfunction

    initial begin
        rst = 1'b1; we = '0; data_in = '0; re = 1'b0;
        @(posedge clk);
        model_step();
        step(1, '0, '0, 1);
        @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_data_out", data_out, 0);
        check("rst_ch_out", ch_out, 0);
        rst = 1'b0;
        @(posedge clk);
        model_step();

        // Single write on channel 1, held until popped.
        step(0, 3'b010, 24'h00A500, 0);
        step(0, '0, '0, 0);
        @(negedge clk);
        check("first_visible_empty", empty, 0);
        check("first_visible_data", data_out, 8'hA5);
        check("first_visible_ch", ch_out, 1);
        repeat (3) step(0, '0, '0, 0);
        step(0, '0, '0, 1);

        // Fill every channel then stream out round-robin.
        repeat (4) step(0, 3'b111, rnd_data(), 0);
        repeat (14) step(0, '0, '0, 1);

        // Overflow on channel 2 without popping.
        repeat (6) step(0, 3'b100, rnd_data(), 0);
        repeat (8) step(0, '0, '0, 1);

        // Reset with buffered data and an active pop.
        repeat (2) step(0, 3'b111, rnd_data(), 0);
        step(1, 3'b111, rnd_data(), 1);
        step(0, 3'b100, rnd_data(), 0);
        repeat (3) step(0, '0, '0, 0);
        step(0, '0, '0, 1);

        // Randomized traffic in phases of differing pressure.
        for (int ph = 0; ph < 30; ph++) begin
            int rp;
            rp = $urandom_range(0, 4);
            for (int n = 0; n < 100; n++) begin
                step(($urandom_range(0, 299) == 0),
                     NC'($urandom),
                     rnd_data(),
                     ($urandom_range(0, 4) < rp));
            end
        end

        repeat (20) step(0, '0, '0, 1);
        step(0, '0, '0, 0);
        @(negedge clk);
        #5;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
